// File: rtl/ps_bigreg_collector_if.sv
// ps_bigreg_collector_if: bus bundle for one PS_BIGREG collector.
//   wr_valid/wr_id/wr_data      snooped mem-map write strobe, index and data
//   big_data/big_valid/big_ready assembled wide word with valid/ready handshake
//   clr_valid/clr_id/clr_ready  freshbit-clear requests back to the mem map
//   err_incomplete/err_dropped  one-cycle error pulses
// The master modport is the collector's view; slave is the mem map/consumer side.
interface ps_bigreg_collector_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SAMPLES    = 16
);
    localparam int unsigned OUT_WIDTH = SAMPLES * DATA_WIDTH;

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_id;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [OUT_WIDTH-1:0]  big_data;
    logic                  big_valid;
    logic                  big_ready;
    logic                  clr_valid;
    logic [ADDR_WIDTH-1:0] clr_id;
    logic                  clr_ready;
    logic                  err_incomplete;
    logic                  err_dropped;

    modport master (
        input  wr_valid, wr_id, wr_data, big_ready, clr_ready,
        output big_data, big_valid, clr_valid, clr_id, err_incomplete, err_dropped
    );

    modport slave (
        output wr_valid, wr_id, wr_data, big_ready, clr_ready,
        input  big_data, big_valid, clr_valid, clr_id, err_incomplete, err_dropped
    );
endinterface

// File: rtl/ps_bigreg_collector.sv
// ps_bigreg_collector: gathers SAMPLES consecutive mem-map entries starting at
// BASE_ID into one wide word, publishes it when the group's VALID ID is written,
// then issues freshbit clears for every ID of the group (sub-words, then VALID).
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    ps_bigreg_collector_if.master (write snoop, wide-word handshake,
//          clear handshake, error pulses); every output is registered.
module ps_bigreg_collector #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BASE_ID    = 1,
    parameter int unsigned SAMPLES    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps_bigreg_collector_if.master bus
);
    localparam int unsigned OUT_WIDTH = SAMPLES * DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(SAMPLES + 1);

    localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ID);
    localparam logic [ADDR_WIDTH-1:0] VALID_A   = ADDR_WIDTH'(BASE_ID + SAMPLES);
    localparam logic [ADDR_WIDTH-1:0] SAMPLES_A = ADDR_WIDTH'(SAMPLES);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(SAMPLES);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;

    // Group must fit in the mem-map index space.
    if ((BASE_ID + SAMPLES) >= (2 ** ADDR_WIDTH)) begin : g_range_chk
        $error("ps_bigreg_collector: BASE_ID+SAMPLES exceeds index space");
    end
    if (SAMPLES == 0) begin : g_samples_chk
        $error("ps_bigreg_collector: SAMPLES must be at least 1");
    end

    logic [1:0]            state_q,     state_d;
    logic [OUT_WIDTH-1:0]  shadow_q,    shadow_d;
    logic [SAMPLES-1:0]    seen_q,      seen_d;
    logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
    logic [OUT_WIDTH-1:0]  big_data_q,  big_data_d;
    logic                  big_valid_q, big_valid_d;
    logic                  clr_valid_q, clr_valid_d;
    logic [ADDR_WIDTH-1:0] clr_id_q,    clr_id_d;
    logic                  err_inc_q,   err_inc_d;
    logic                  err_drop_q,  err_drop_d;

    // ID decode: the offset wraps for IDs below BASE_ID, so a single compare
    // against SAMPLES selects exactly the sub-word range.
    logic [ADDR_WIDTH-1:0] off_c;
    logic                  is_sub_c;
    logic                  is_valid_c;
    logic                  owned_wr_c;

    assign off_c      = bus.wr_id - BASE_A;
    assign is_sub_c   = off_c < SAMPLES_A;
    assign is_valid_c = bus.wr_id == VALID_A;
    assign owned_wr_c = bus.wr_valid && (is_sub_c || is_valid_c);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        seen_d      = seen_q;
        cnt_d       = cnt_q;
        big_data_d  = big_data_q;
        big_valid_d = big_valid_q;
        clr_valid_d = clr_valid_q;
        clr_id_d    = clr_id_q;
        err_inc_d   = 1'b0;
        err_drop_d  = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                if (bus.wr_valid && is_sub_c) begin
                    for (int unsigned k = 0; k < SAMPLES; k++) begin
                        if (off_c == ADDR_WIDTH'(k)) begin
                            shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
                            seen_d[k]                            = 1'b1;
                        end
                    end
                end else if (bus.wr_valid && is_valid_c) begin
                    if (&seen_q) begin
                        big_data_d  = shadow_q;
                        big_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        err_inc_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                err_drop_d = owned_wr_c;
                if (big_valid_q && bus.big_ready) begin
                    big_valid_d = 1'b0;
                    cnt_d       = '0;
                    clr_valid_d = 1'b1;
                    clr_id_d    = BASE_A;
                    state_d     = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                err_drop_d = owned_wr_c;
                if (clr_valid_q && bus.clr_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        // VALID_ID clear accepted: group re-armed.
                        clr_valid_d = 1'b0;
                        seen_d      = '0;
                        state_d     = ST_COLLECT;
                    end else begin
                        cnt_d    = cnt_q + CNT_WIDTH'(1);
                        clr_id_d = BASE_A + ADDR_WIDTH'(cnt_d);
                    end
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            shadow_q    <= '0;
            seen_q      <= '0;
            cnt_q       <= '0;
            big_data_q  <= '0;
            big_valid_q <= 1'b0;
            clr_valid_q <= 1'b0;
            clr_id_q    <= '0;
            err_inc_q   <= 1'b0;
            err_drop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            seen_q      <= seen_d;
            cnt_q       <= cnt_d;
            big_data_q  <= big_data_d;
            big_valid_q <= big_valid_d;
            clr_valid_q <= clr_valid_d;
            clr_id_q    <= clr_id_d;
            err_inc_q   <= err_inc_d;
            err_drop_q  <= err_drop_d;
        end
    end

    assign bus.big_data       = big_data_q;
    assign bus.big_valid      = big_valid_q;
    assign bus.clr_valid      = clr_valid_q;
    assign bus.clr_id         = clr_id_q;
    assign bus.err_incomplete = err_inc_q;
    assign bus.err_dropped    = err_drop_q;
endmodule

// File: tb/tb_ps_bigreg_collector.sv
// tb_ps_bigreg_collector: directed bench for two collector configurations,
// seed (BASE_ID=1, SAMPLES=16) and chan_mux (BASE_ID=30, SAMPLES=2).
module tb_ps_bigreg_collector;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ps_bigreg_collector_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SAMPLES(16)) sd_if ();
    ps_bigreg_collector_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .SAMPLES(2))  cm_if ();

    ps_bigreg_collector #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BASE_ID(1), .SAMPLES(16)) u_sd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sd_if)
    );

    ps_bigreg_collector #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .BASE_ID(30), .SAMPLES(2)) u_cm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cm_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hs;
    int exp_id;
    logic [255:0] exp_sd;
    logic [255:0] held;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sd_wr(input logic [7:0] id, input logic [15:0] d);
        sd_if.wr_valid = 1'b1;
        sd_if.wr_id    = id;
        sd_if.wr_data  = d;
        tick();
        sd_if.wr_valid = 1'b0;
    endtask

    task automatic cm_wr(input logic [7:0] id, input logic [15:0] d);
        cm_if.wr_valid = 1'b1;
        cm_if.wr_id    = id;
        cm_if.wr_data  = d;
        tick();
        cm_if.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        sd_if.wr_valid  = 1'b0;
        sd_if.wr_id     = '0;
        sd_if.wr_data   = '0;
        sd_if.big_ready = 1'b0;
        sd_if.clr_ready = 1'b0;
        cm_if.wr_valid  = 1'b0;
        cm_if.wr_id     = '0;
        cm_if.wr_data   = '0;
        cm_if.big_ready = 1'b0;
        cm_if.clr_ready = 1'b0;
        for (int k = 0; k < 16; k++) exp_sd[k*16 +: 16] = 16'(32'h1000 + k);

        // Reset state
        tick();
        tick();
        check("rst_big_valid", 256'(sd_if.big_valid), 256'(1'b0));
        check("rst_big_data",  256'(sd_if.big_data),  256'(0));
        check("rst_clr_valid", 256'(sd_if.clr_valid), 256'(1'b0));
        check("rst_clr_id",    256'(sd_if.clr_id),    256'(0));
        check("rst_err_inc",   256'(sd_if.err_incomplete), 256'(1'b0));
        check("rst_err_drop",  256'(sd_if.err_dropped),    256'(1'b0));
        check("rst_cm_data",   256'(cm_if.big_data),  256'(0));
        rst_n = 1'b1;
        tick();

        // Foreign traffic: no errors, no state change
        sd_wr(8'd0, 16'h1111);
        check("frgn0_err", 256'({sd_if.err_incomplete, sd_if.err_dropped}), 256'(0));
        sd_wr(8'd18, 16'h2222);
        check("frgn18_err", 256'({sd_if.err_incomplete, sd_if.err_dropped}), 256'(0));
        sd_wr(8'd255, 16'h3333);
        check("frgn255_err", 256'({sd_if.err_incomplete, sd_if.err_dropped}), 256'(0));
        check("frgn_big_valid", 256'(sd_if.big_valid), 256'(1'b0));

        // Incomplete group, then completion
        for (int id = 1; id <= 15; id++) sd_wr(8'(id), 16'(32'h1000 + id - 1));
        sd_wr(8'd17, 16'hFFFF);
        check("inc_pulse", 256'(sd_if.err_incomplete), 256'(1'b1));
        check("inc_no_valid", 256'(sd_if.big_valid), 256'(1'b0));
        tick();
        check("inc_pulse_end", 256'(sd_if.err_incomplete), 256'(1'b0));
        sd_wr(8'd16, 16'h100F);
        check("pre_valid_low", 256'(sd_if.big_valid), 256'(1'b0));
        sd_wr(8'd17, 16'h0000);
        check("valid_latency", 256'(sd_if.big_valid), 256'(1'b1));
        check("sub0", 256'(sd_if.big_data[15:0]), 256'(16'h1000));
        check("sub15", 256'(sd_if.big_data[255:240]), 256'(16'h100F));
        check("big_word", sd_if.big_data, exp_sd);

        // Busy drop in HOLD, then backpressure on big_ready
        sd_wr(8'd5, 16'hDEAD);
        check("hold_drop", 256'(sd_if.err_dropped), 256'(1'b1));
        check("hold_drop_data", sd_if.big_data, exp_sd);
        tick();
        check("hold_drop_end", 256'(sd_if.err_dropped), 256'(1'b0));
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 256'(sd_if.big_valid), 256'(1'b1));
            check("bp_data", sd_if.big_data, exp_sd);
            tick();
        end
        sd_if.big_ready = 1'b1;
        tick();
        sd_if.big_ready = 1'b0;
        check("hs_valid_low", 256'(sd_if.big_valid), 256'(1'b0));

        // Clears with clr_ready toggling
        exp_id = 1;
        hs     = 0;
        for (int cyc = 0; cyc < 80 && hs < 17; cyc++) begin
            sd_if.clr_ready = (cyc % 2) == 1;
            check("bp_clr_valid", 256'(sd_if.clr_valid), 256'(1'b1));
            check("bp_clr_id", 256'(sd_if.clr_id), 256'(exp_id));
            if (sd_if.clr_ready) begin
                hs++;
                exp_id++;
            end
            tick();
        end
        sd_if.clr_ready = 1'b0;
        check("bp_clr_count", 256'(hs), 256'(17));
        check("bp_clr_done", 256'(sd_if.clr_valid), 256'(1'b0));
        tick();
        check("bp_clr_quiet", 256'(sd_if.clr_valid), 256'(1'b0));

        // Seen mask was cleared by the clear sequence
        sd_wr(8'd17, 16'h0000);
        check("rearm_inc", 256'(sd_if.err_incomplete), 256'(1'b1));
        check("rearm_no_valid", 256'(sd_if.big_valid), 256'(1'b0));

        // Full seed load, ready signals held high
        for (int id = 1; id <= 16; id++) sd_wr(8'(id), 16'(32'h1000 + id - 1));
        sd_if.big_ready = 1'b1;
        sd_if.clr_ready = 1'b1;
        check("full_pre_valid", 256'(sd_if.big_valid), 256'(1'b0));
        sd_wr(8'd17, 16'h0000);
        check("full_valid", 256'(sd_if.big_valid), 256'(1'b1));
        check("full_word", sd_if.big_data, exp_sd);
        tick();
        sd_if.big_ready = 1'b0;
        check("full_hs", 256'(sd_if.big_valid), 256'(1'b0));
        for (int i = 1; i <= 17; i++) begin
            check("full_clr_valid", 256'(sd_if.clr_valid), 256'(1'b1));
            check("full_clr_id", 256'(sd_if.clr_id), 256'(i));
            tick();
        end
        check("full_clr_done", 256'(sd_if.clr_valid), 256'(1'b0));

        // Reset after the fifth clear is accepted
        for (int id = 1; id <= 16; id++) sd_wr(8'(id), 16'(32'h3000 + id));
        sd_wr(8'd17, 16'h0000);
        check("rc_valid", 256'(sd_if.big_valid), 256'(1'b1));
        sd_if.big_ready = 1'b1;
        tick();
        sd_if.big_ready = 1'b0;
        repeat (5) tick();
        check("rc_clr_id6", 256'(sd_if.clr_id), 256'(6));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rc_big_valid", 256'(sd_if.big_valid), 256'(1'b0));
        check("rc_big_data", sd_if.big_data, 256'(0));
        check("rc_clr_valid", 256'(sd_if.clr_valid), 256'(1'b0));
        check("rc_clr_id", 256'(sd_if.clr_id), 256'(0));
        check("rc_errs", 256'({sd_if.err_incomplete, sd_if.err_dropped}), 256'(0));
        tick();
        check("rc_no_clear", 256'(sd_if.clr_valid), 256'(1'b0));
        sd_wr(8'd17, 16'h0000);
        check("rc_inc", 256'(sd_if.err_incomplete), 256'(1'b1));
        check("rc_no_valid", 256'(sd_if.big_valid), 256'(1'b0));
        sd_if.clr_ready = 1'b0;

        // chan_mux: overwrite, busy drop, simultaneous write and handshake
        cm_wr(8'd30, 16'hAAAA);
        cm_wr(8'd30, 16'h5555);
        cm_wr(8'd31, 16'h1234);
        check("cm_pre_valid", 256'(cm_if.big_valid), 256'(1'b0));
        cm_wr(8'd32, 16'h0000);
        check("cm_valid", 256'(cm_if.big_valid), 256'(1'b1));
        check("cm_word", 256'(cm_if.big_data), 256'(32'h1234_5555));
        cm_wr(8'd33, 16'hBEEF);
        check("cm_foreign_hold", 256'(cm_if.err_dropped), 256'(1'b0));
        cm_wr(8'd30, 16'hFFFF);
        check("cm_drop", 256'(cm_if.err_dropped), 256'(1'b1));
        check("cm_drop_word", 256'(cm_if.big_data), 256'(32'h1234_5555));
        cm_if.big_ready = 1'b1;
        cm_wr(8'd31, 16'h0000);
        cm_if.big_ready = 1'b0;
        check("cm_same_drop", 256'(cm_if.err_dropped), 256'(1'b1));
        check("cm_same_hs", 256'(cm_if.big_valid), 256'(1'b0));
        check("cm_same_word", 256'(cm_if.big_data), 256'(32'h1234_5555));
        cm_if.clr_ready = 1'b1;
        for (int i = 30; i <= 32; i++) begin
            check("cm_clr_valid", 256'(cm_if.clr_valid), 256'(1'b1));
            check("cm_clr_id", 256'(cm_if.clr_id), 256'(i));
            tick();
        end
        cm_if.clr_ready = 1'b0;
        check("cm_clr_done", 256'(cm_if.clr_valid), 256'(1'b0));
        cm_wr(8'd32, 16'h0000);
        check("cm_rearm_inc", 256'(cm_if.err_incomplete), 256'(1'b1));
        check("cm_rearm_no_valid", 256'(cm_if.big_valid), 256'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
